vx_elastic_pipe: RTL



---
 rtl/vx_pipe_pkg.sv | 19 +
 rtl/vx_skid_buffer.sv | 62 ++++++
 rtl/vx_elastic_pipe.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/vx_pipe_pkg.sv
// -----------------------------------------------------------------------------
// vx_pipe_pkg
//   Shared constants and helpers for the valid/ready pipeline slice
//   (vx_elastic_pipe, vx_skid_buffer).
//   No ports; imported with "import vx_pipe_pkg::*;".
// -----------------------------------------------------------------------------
package vx_pipe_pkg;

  // Number of beats the optional input skid buffer can hold.
  localparam int SKID_ENTRIES = 1;

  // Width of an occupancy counter for a pipe of 'depth' stages.
  // The counter must reach depth + SKID_ENTRIES, so $clog2(depth + 2)
  // covers every value including zero.
  function automatic int pipe_cntw(input int depth);
    return $clog2(depth + SKID_ENTRIES + 1);
  endfunction

endpackage : vx_pipe_pkg

// File: rtl/vx_skid_buffer.sv
// -----------------------------------------------------------------------------
// vx_skid_buffer
//   One-entry skid buffer. Its upstream ready is a flop output, so no
//   combinational path runs from ready_out back to ready_in. When the
//   buffer is empty, beats pass straight through with no added latency.
//   If the consumer stalls while a beat is offered, that beat is parked.
//   A parked beat is always presented ahead of any new input.
//
// Ports
//   clk        in   1      clock, rising edge
//   reset      in   1      synchronous, active-high
//   valid_in   in   1      upstream payload valid
//   data_in    in   DATAW  upstream payload
//   ready_in   out  1      buffer empty: upstream may transfer this cycle
//   valid_out  out  1      payload available to the consumer
//   data_out   out  DATAW  payload to the consumer
//   ready_out  in   1      consumer accepts this cycle
// -----------------------------------------------------------------------------
module vx_skid_buffer
  import vx_pipe_pkg::*;
#(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [DATAW-1:0] data_in,
  output logic             ready_in,
  output logic             valid_out,
  output logic [DATAW-1:0] data_out,
  input  logic             ready_out
);

  logic             full_q;
  logic [DATAW-1:0] hold_q;
  logic             park;

  // A beat is parked only when it is accepted from upstream (which
  // requires the buffer to be empty) and the consumer refuses it.
  assign park = !full_q && valid_in && !ready_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
    end else if (full_q) begin
      if (ready_out) full_q <= 1'b0;
    end else if (park) begin
      full_q <= 1'b1;
    end
  end

  // NOTE: payload registers carry no reset; the qualifying valid/full flag
  // is what gets cleared, which keeps the wide datapath flops cheap.
  always_ff @(posedge clk) begin
    if (park) hold_q <= data_in;
  end

  assign ready_in  = !full_q;
  assign valid_out = full_q | valid_in;
  assign data_out  = full_q ? hold_q : data_in;

endmodule : vx_skid_buffer

// File: rtl/vx_elastic_pipe.sv
// -----------------------------------------------------------------------------
// vx_elastic_pipe
//   A DEPTH-stage valid/ready pipeline with per-stage valid bits and
//   backpressure. Bubbles collapse whenever the consumer stalls. Beats
//   leave in arrival order and are never dropped or duplicated.
//   With REG_READY=1, a one-entry skid buffer sits at the input, so that
//   ready_in comes straight from a flop.
//
// Ports
//   clk        in   1      clock, rising edge
//   reset      in   1      synchronous, active-high
//   valid_in   in   1      upstream payload valid
//   data_in    in   DATAW  upstream payload
//   ready_in   out  1      pipe accepts data_in this cycle
//   valid_out  out  1      last stage holds a valid payload
//   data_out   out  DATAW  last-stage payload
//   ready_out  in   1      downstream accepts this cycle
//   count      out  CNTW   valid entries held (stages + skid)
//   empty      out  1      count == 0
// -----------------------------------------------------------------------------
module vx_elastic_pipe
  import vx_pipe_pkg::*;
#(
  parameter int DATAW     = 8,
  parameter int DEPTH     = 2,
  parameter int REG_READY = 0,
  parameter int CNTW      = pipe_cntw(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [DATAW-1:0] data_in,
  output logic             ready_in,
  output logic             valid_out,
  output logic [DATAW-1:0] data_out,
  input  logic             ready_out,
  output logic [CNTW-1:0]  count,
  output logic             empty
);

  // Stage-0 feed: either the raw input or the skid buffer's output.
  logic             s_valid;
  logic [DATAW-1:0] s_data;

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DATAW-1:0] d [DEPTH];

  // ---------------------------------------------------------------------------
  // Optional input skid buffer
  // ---------------------------------------------------------------------------
  if (REG_READY != 0) begin : g_skid
    vx_skid_buffer #(
      .DATAW (DATAW)
    ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .ready_in  (ready_in),
      .valid_out (s_valid),
      .data_out  (s_data),
      .ready_out (adv[0])
    );
  end else begin : g_noskid
    // ready_in depends only on stage state and ready_out, never on valid_in.
    assign s_valid  = valid_in;
    assign s_data   = data_in;
    assign ready_in = adv[0];
  end

  // ---------------------------------------------------------------------------
  // Stages
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             v_q;
    logic [DATAW-1:0] d_q;
    logic             v_nxt;
    logic [DATAW-1:0] d_nxt;

    // Stage i may load whenever there is a hole at or beyond it, or when the
    // last stage is draining. This is the unrolled form of
    // adv[i] = !v[i] | adv[i+1], with adv[DEPTH-1] = !v[DEPTH-1] | ready_out.
    assign adv[i] = ready_out | ~(&v[DEPTH-1:i]);

    if (i == 0) begin : g_head
      assign v_nxt = s_valid;
      assign d_nxt = s_data;
    end else begin : g_body
      assign v_nxt = v[i-1];
      assign d_nxt = d[i-1];
    end

    always_ff @(posedge clk) begin
      if (reset)       v_q <= 1'b0;
      else if (adv[i]) v_q <= v_nxt;
    end

    always_ff @(posedge clk) begin
      if (adv[i]) d_q <= d_nxt;
    end

    assign v[i] = v_q;
    assign d[i] = d_q;
  end

  assign valid_out = v[DEPTH-1];
  assign data_out  = d[DEPTH-1];

  // ---------------------------------------------------------------------------
  // Occupancy
  // ---------------------------------------------------------------------------
  // The counter tracks port-level handshakes, not the stage valid bits, so
  // that a beat parked in the skid buffer is included in the count.
  logic            in_xfer;
  logic            out_xfer;
  logic [CNTW-1:0] count_q;

  assign in_xfer  = valid_in  & ready_in;
  assign out_xfer = valid_out & ready_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (in_xfer != out_xfer) begin
      count_q <= in_xfer ? count_q + CNTW'(1) : count_q - CNTW'(1);
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);

  // ---------------------------------------------------------------------------
  // Interface invariants
  // ---------------------------------------------------------------------------
  a_hold_stalled : assert property (@(posedge clk) disable iff (reset)
    (valid_out && !ready_out) |=> (valid_out && $stable(data_out)));

  a_count_bound : assert property (@(posedge clk) disable iff (reset)
    int'(count_q) <= DEPTH + REG_READY);

endmodule : vx_elastic_pipe
